ov7670_cfg_sequencer: RTL and testbench

- Upstream driver of the SCCB master. Walks an internal ROM of OV7670 register/value pairs and issues one SCCB write per entry.
- Handles two marker entries: a software-reset delay and an end-of-table marker. Reports done/error to the top-level camera bring-up logic.
- Runs on the system clock; the master's slow bus clock is hidden behind a level handshake on its ready line.

---
 rtl/ov7670_cfg_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_ov7670_cfg_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ov7670_cfg_sequencer.sv
// OV7670 register bring-up: walks a ROM of {reg, value} pairs and hands each one to the SCCB master.
// Optional read-back verification of every write except the reset entry is enabled by defining CFG_VERIFY_EN.
module ov7670_cfg_sequencer #(
   parameter logic [6:0] DEV_ADDR    = 7'h21,
   parameter int         CLK_HZ      = 27000000,
   parameter int         DELAY_MS    = 10,
   parameter int         GAP_CYC     = 16,
   parameter int         TIMEOUT_CYC = 1000000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_sccb_ready,
   input  logic [7:0] i_sccb_dout,
   output logic [6:0] o_sccb_addr,
   output logic [7:0] o_sccb_reg,
   output logic [7:0] o_sccb_data,
   output logic       o_sccb_rd_wr,
   output logic       o_sccb_en,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_error,
   output logic [5:0] o_index
);

   localparam logic [31:0] DELAY_LAST   = 32'(CLK_HZ / 1000 * DELAY_MS - 1);
   localparam logic [31:0] GAP_LAST     = 32'(GAP_CYC - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
   localparam logic [15:0] END_MARK     = 16'hFFFF;
   localparam logic [15:0] DELAY_MARK   = 16'hFFF0;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE,
      S_GAP, S_DELAY, S_DONE, S_ERROR
   } state_t;

   state_t      state;
   logic [31:0] cnt;
   logic [15:0] rom_entry;

   assign o_sccb_addr = DEV_ADDR;

   // Index 63 and every unlisted index fall through to the end marker.
   always_comb begin
      rom_entry = END_MARK;
      case (o_index)
         6'd0: rom_entry = 16'h1280;
         6'd1: rom_entry = DELAY_MARK;
         6'd2: rom_entry = 16'h1204;
         6'd3: rom_entry = 16'h40D0;
         6'd4: rom_entry = 16'h1180;
         6'd5: rom_entry = 16'h0C00;
         6'd6: rom_entry = 16'h3E00;
         6'd7: rom_entry = 16'h8C00;
         default: rom_entry = END_MARK;
      endcase
   end

`ifndef CFG_VERIFY_EN
   logic unused_dout;
   assign unused_dout = ^i_sccb_dout;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         o_index      <= '0;
         o_sccb_reg   <= '0;
         o_sccb_data  <= '0;
         o_sccb_rd_wr <= 1'b0;
         o_sccb_en    <= 1'b0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_error      <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (i_start) begin
                  state        <= S_FETCH;
                  cnt          <= '0;
                  o_index      <= '0;
                  o_sccb_rd_wr <= 1'b0;
                  o_busy       <= 1'b1;
                  o_done       <= 1'b0;
                  o_error      <= 1'b0;
               end
            end
            S_FETCH: begin
               o_sccb_reg  <= rom_entry[15:8];
               o_sccb_data <= rom_entry[7:0];
               cnt         <= '0;
               if (rom_entry == END_MARK) begin
                  state  <= S_DONE;
                  o_done <= 1'b1;
                  o_busy <= 1'b0;
               end else if (rom_entry == DELAY_MARK) begin
                  state <= S_DELAY;
               end else begin
                  state <= S_ISSUE;
               end
            end
            // Request only once the master is seen idle; en is held until it captures.
            S_ISSUE: begin
               if (i_sccb_ready) begin
                  o_sccb_en <= 1'b1;
                  state     <= S_WAIT_ACK;
                  cnt       <= '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  state   <= S_ERROR;
                  o_error <= 1'b1;
                  o_busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_WAIT_ACK: begin
               if (!i_sccb_ready) begin
                  o_sccb_en <= 1'b0;
                  state     <= S_WAIT_DONE;
                  cnt       <= '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  o_sccb_en <= 1'b0;
                  state     <= S_ERROR;
                  o_error   <= 1'b1;
                  o_busy    <= 1'b0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_WAIT_DONE: begin
               if (i_sccb_ready) begin
                  cnt <= '0;
`ifdef CFG_VERIFY_EN
                  // Every write except the reset register is followed by a read of the same register.
                  if (!o_sccb_rd_wr && o_index != 6'd0) begin
                     o_sccb_rd_wr <= 1'b1;
                     state        <= S_ISSUE;
                  end else if (o_sccb_rd_wr && i_sccb_dout != o_sccb_data) begin
                     state   <= S_ERROR;
                     o_error <= 1'b1;
                     o_busy  <= 1'b0;
                  end else begin
                     o_sccb_rd_wr <= 1'b0;
                     state        <= S_GAP;
                  end
`else
                  state <= S_GAP;
`endif
               end else if (cnt == TIMEOUT_LAST) begin
                  state   <= S_ERROR;
                  o_error <= 1'b1;
                  o_busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt     <= '0;
                  o_index <= o_index + 6'd1;
                  state   <= S_FETCH;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_DELAY: begin
               if (cnt == DELAY_LAST) begin
                  cnt     <= '0;
                  o_index <= o_index + 6'd1;
                  state   <= S_FETCH;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Directed bench for ov7670_cfg_sequencer: table walk, delay marker, timeout, ready-low issue, mid-transaction reset.
module tb_ov7670_cfg_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       ready;
   logic [7:0] dout;
   logic [6:0] sccb_addr;
   logic [7:0] sccb_reg;
   logic [7:0] sccb_data;
   logic       rd_wr;
   logic       en;
   logic       busy;
   logic       done;
   logic       error;
   logic [5:0] index;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Master model behaviour: 0 = acks 3 cycles after en, 1 = never drops ready, 2 = bench drives ready.
   int   model_mode = 0;
   logic bad_40     = 1'b0;
   logic [15:0] cap_q[$];
   logic [15:0] exp_q[$];
   int          comp_q[$];
   int          en_rise_q[$];

   ov7670_cfg_sequencer #(
      .DEV_ADDR(7'h21), .CLK_HZ(1000000), .DELAY_MS(1), .GAP_CYC(16), .TIMEOUT_CYC(100)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_sccb_ready(ready), .i_sccb_dout(dout),
      .o_sccb_addr(sccb_addr), .o_sccb_reg(sccb_reg), .o_sccb_data(sccb_data),
      .o_sccb_rd_wr(rd_wr), .o_sccb_en(en), .o_busy(busy), .o_done(done),
      .o_error(error), .o_index(index)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // SCCB master model
   initial begin
      ready = 1'b1;
      dout  = 8'h00;
      forever begin
         @(negedge clk);
         if (model_mode == 0 && en && ready && !rst) begin
            repeat (3) @(negedge clk);
            if (!rd_wr) cap_q.push_back({sccb_reg, sccb_data});
            if (rd_wr) dout = (bad_40 && sccb_reg == 8'h40) ? 8'hD1 : sccb_data;
            ready = 1'b0;
            repeat (5) @(negedge clk);
            ready = 1'b1;
            comp_q.push_back(cyc);
         end
      end
   end

   // en rising-edge monitor
   initial begin
      logic en_prev;
      en_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (en && !en_prev) en_rise_q.push_back(cyc);
         en_prev = en;
      end
   end

   initial begin
      int t;
      int diff;
      logic [15:0] got;
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);

      // reset values
      check("rst_en", en, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_index", index, 6'd0);
      check("rst_reg", sccb_reg, 8'h00);
      check("rst_data", sccb_data, 8'h00);
      check("rst_rdwr", rd_wr, 1'b0);
      check("rst_addr", sccb_addr, 7'h21);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // full table walk
      exp_q = '{16'h1280, 16'h1204, 16'h40D0, 16'h1180, 16'h0C00, 16'h3E00, 16'h8C00};
      cap_q.delete(); comp_q.delete(); en_rise_q.delete();
      pulse_start();
      check("walk_busy", busy, 1'b1);
      for (t = 0; t < 3000 && !done; t++) @(negedge clk);
      check("walk_done", done, 1'b1);
      check("walk_not_busy", busy, 1'b0);
      check("walk_error", error, 1'b0);
      check("walk_index", index, 6'd8);
      check("walk_count", cap_q.size(), 7);
      while (exp_q.size() > 0) begin
         got = (cap_q.size() > 0) ? cap_q.pop_front() : 16'hxxxx;
         check("walk_entry", got, exp_q.pop_front());
      end
      // delay marker: second en no earlier than 1000 cycles after first completion
      diff = (comp_q.size() > 0 && en_rise_q.size() > 1) ? en_rise_q[1] - comp_q[0] : 0;
      check("delay_gap", diff >= 1000, 1'b1);

      // timeout: master never drops ready
      model_mode = 1;
      en_rise_q.delete();
      pulse_start();
      for (t = 0; t < 30 && !en; t++) @(negedge clk);
      check("to_en_seen", en, 1'b1);
      for (t = 0; t < 101 && !error; t++) @(negedge clk);
      check("to_error", error, 1'b1);
      check("to_within", t <= 101, 1'b1);
      check("to_index", index, 6'd0);
      check("to_en_low", en, 1'b0);
      check("to_busy", busy, 1'b0);
      check("to_done", done, 1'b0);

      // ready held low at issue: en must wait
      model_mode = 2;
      @(negedge clk);
      ready = 1'b0;
      cap_q.delete();
      pulse_start();
      check("rl_error_clr", error, 1'b0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("rl_en_low", en, 1'b0);
      end
      ready = 1'b1;
      model_mode = 0;
      for (t = 0; t < 3 && !en; t++) @(negedge clk);
      check("rl_en_rise", en, 1'b1);

      // reset during WAIT_DONE of entry 3
      for (t = 0; t < 3000 && !(index == 6'd3 && !en && !ready && busy); t++) @(negedge clk);
      check("mid_reached", index, 6'd3);
      check("mid_first_cap", (cap_q.size() > 0) ? cap_q[0] : 16'h0000, 16'h1280);
      rst = 1'b1;
      #1;
      check("mid_en", en, 1'b0);
      check("mid_busy", busy, 1'b0);
      check("mid_index", index, 6'd0);
      check("mid_reg", sccb_reg, 8'h00);
      check("mid_data", sccb_data, 8'h00);
      check("mid_addr", sccb_addr, 7'h21);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (t = 0; t < 20 && !ready; t++) @(negedge clk);
      cap_q.delete();
      pulse_start();
      check("re_index", index, 6'd0);
      check("re_busy", busy, 1'b1);
      for (t = 0; t < 3000 && !done; t++) @(negedge clk);
      check("re_done", done, 1'b1);
      check("re_count", cap_q.size(), 7);
      check("re_first", (cap_q.size() > 0) ? cap_q[0] : 16'h0000, 16'h1280);

`ifdef CFG_VERIFY_EN
      // read-back mismatch on register 0x40
      bad_40 = 1'b1;
      pulse_start();
      for (t = 0; t < 3000 && !error; t++) @(negedge clk);
      check("vf_error", error, 1'b1);
      check("vf_index", index, 6'd3);
      check("vf_en", en, 1'b0);
      check("vf_done", done, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
